// File: rtl/nav_msg_serializer_pkg.sv
// Shared defaults and state encoding for the GPS nav-data serializer.
package nav_msg_serializer_pkg;

  localparam int unsigned CHIPS_PER_BIT_DEF      = 20460;
  localparam int unsigned WORD_BITS_DEF          = 30;
  localparam int unsigned WORDS_PER_SUBFRAME_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/nav_msg_serializer_if.sv
// Valid/ready word handshake between the nav-message source and the serializer.
interface nav_msg_serializer_if
  import nav_msg_serializer_pkg::*;
#(
  parameter int unsigned WORD_BITS = WORD_BITS_DEF
);

  logic [WORD_BITS-1:0] word_data;
  logic                 word_valid;
  logic                 word_ready;

  modport master (output word_data, output word_valid, input  word_ready);
  modport slave  (input  word_data, input  word_valid, output word_ready);

endinterface

// File: rtl/nav_bit_epoch_counter.sv
// Free-running chip counter marking the last chip of each nav-bit epoch.
module nav_bit_epoch_counter
  import nav_msg_serializer_pkg::*;
#(
  parameter int unsigned CHIPS_PER_BIT = CHIPS_PER_BIT_DEF
) (
  input  logic clk_in,
  input  logic rst,
  output logic bit_strobe
);

  localparam int unsigned CNT_W = $clog2(CHIPS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHIPS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;

  // Strobe is registered from the next count so it coincides with cnt == last.
  always_comb begin
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    strobe_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign bit_strobe = strobe_q;

endmodule

// File: rtl/nav_msg_serializer.sv
// 50 bps nav-data serializer: buffers one word, shifts it out MSB first per epoch,
// and modulates the C/A chip stream with the current data bit.
module nav_msg_serializer
  import nav_msg_serializer_pkg::*;
#(
  parameter int unsigned CHIPS_PER_BIT      = CHIPS_PER_BIT_DEF,
  parameter int unsigned WORD_BITS          = WORD_BITS_DEF,
  parameter int unsigned WORDS_PER_SUBFRAME = WORDS_PER_SUBFRAME_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst,
  nav_msg_serializer_if.slave  bus,
  input  logic                 code_chip,
  output logic                 nav_bit,
  output logic                 bit_strobe,
  output logic                 subframe_start,
  output logic                 tx_chip,
  output logic                 underrun
);

  localparam int unsigned BIT_W  = $clog2(WORD_BITS);
  localparam int unsigned WIDX_W = $clog2(WORDS_PER_SUBFRAME);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS_PER_SUBFRAME - 1);

  state_e                state_q, state_d;
  logic                  word_ready_q, word_ready_d;
  logic [WORD_BITS-1:0]  buf_q, buf_d;
  logic [WORD_BITS-1:0]  shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic [WIDX_W-1:0]     word_idx_q, word_idx_d;
  logic [WIDX_W-1:0]     widx_inc;
  logic                  nav_bit_q, nav_bit_d;
  logic                  sfs_q, sfs_d;
  logic                  tx_chip_q, tx_chip_d;
  logic                  underrun_q, underrun_d;
  logic                  strobe;

  nav_bit_epoch_counter #(
    .CHIPS_PER_BIT (CHIPS_PER_BIT)
  ) u_epoch (
    .clk_in     (clk_in),
    .rst        (rst),
    .bit_strobe (strobe)
  );

  // Handshake capture, epoch-boundary sequencing and chip modulation.
  always_comb begin
    state_d      = state_q;
    word_ready_d = word_ready_q;
    buf_d        = buf_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    word_idx_d   = word_idx_q;
    nav_bit_d    = nav_bit_q;
    sfs_d        = sfs_q;
    underrun_d   = 1'b0;
    tx_chip_d    = code_chip ^ nav_bit_q;
    widx_inc     = (word_idx_q == WIDX_LAST) ? '0 : word_idx_q + WIDX_W'(1);

    if (bus.word_valid && word_ready_q) begin
      buf_d        = bus.word_data;
      word_ready_d = 1'b0;
    end

    if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (!word_ready_q) begin
            state_d      = ST_RUN;
            shreg_d      = buf_q;
            word_ready_d = 1'b1;
            bit_idx_d    = '0;
            word_idx_d   = '0;
            nav_bit_d    = buf_q[WORD_BITS-1];
            sfs_d        = 1'b1;
          end
        end
        ST_RUN: begin
          if (bit_idx_q != BIT_LAST) begin
            shreg_d   = shreg_q << 1;
            bit_idx_d = bit_idx_q + BIT_W'(1);
            nav_bit_d = shreg_q[WORD_BITS-2];
            sfs_d     = 1'b0;
          end else if (!word_ready_q) begin
            // Back-to-back word: no gap, subframe position advances.
            shreg_d      = buf_q;
            word_ready_d = 1'b1;
            bit_idx_d    = '0;
            word_idx_d   = widx_inc;
            nav_bit_d    = buf_q[WORD_BITS-1];
            sfs_d        = (widx_inc == '0);
          end else begin
            state_d    = ST_IDLE;
            bit_idx_d  = '0;
            word_idx_d = '0;
            nav_bit_d  = 1'b0;
            sfs_d      = 1'b0;
            underrun_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      word_ready_q <= 1'b1;
      buf_q        <= '0;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      word_idx_q   <= '0;
      nav_bit_q    <= 1'b0;
      sfs_q        <= 1'b0;
      tx_chip_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_ready_q <= word_ready_d;
      buf_q        <= buf_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      word_idx_q   <= word_idx_d;
      nav_bit_q    <= nav_bit_d;
      sfs_q        <= sfs_d;
      tx_chip_q    <= tx_chip_d;
      underrun_q   <= underrun_d;
    end
  end

  assign bus.word_ready  = word_ready_q;
  assign nav_bit         = nav_bit_q;
  assign bit_strobe      = strobe;
  assign subframe_start  = sfs_q;
  assign tx_chip         = tx_chip_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_nav_msg_serializer.sv
// Scoreboard bench for nav_msg_serializer with a per-epoch behavioural model.
module tb_nav_msg_serializer;

  localparam int unsigned CPB = 8;
  localparam int unsigned WB  = 30;
  localparam int unsigned WPS = 10;

  logic clk_in    = 1'b0;
  logic rst       = 1'b1;
  logic code_chip = 1'b0;
  logic nav_bit, bit_strobe, subframe_start, tx_chip, underrun;

  nav_msg_serializer_if #(.WORD_BITS(WB)) bus ();

  nav_msg_serializer #(
    .CHIPS_PER_BIT      (CPB),
    .WORD_BITS          (WB),
    .WORDS_PER_SUBFRAME (WPS)
  ) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .bus            (bus),
    .code_chip      (code_chip),
    .nav_bit        (nav_bit),
    .bit_strobe     (bit_strobe),
    .subframe_start (subframe_start),
    .tx_chip        (tx_chip),
    .underrun       (underrun)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  bit stop_feed = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b, want %b", name, $time, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nav_bit"},        nav_bit,        1'b0);
    check({tag, "_bit_strobe"},     bit_strobe,     1'b0);
    check({tag, "_subframe_start"}, subframe_start, 1'b0);
    check({tag, "_tx_chip"},        tx_chip,        1'b0);
    check({tag, "_underrun"},       underrun,       1'b0);
    check({tag, "_word_ready"},     bus.word_ready, 1'b1);
  endtask

  // Reference model: words accepted wait in `pending`; each load expands into
  // a queue of remaining data bits, one consumed per epoch boundary.
  int                cyc;
  bit                exp_nav, exp_sfs, exp_ready, exp_under, exp_tx, running;
  int                widx;
  bit                bitq[$];
  logic [WB-1:0]     pending[$];

  always @(negedge clk_in) begin
    if (!rst) begin
      cyc = 0; exp_nav = 0; exp_sfs = 0; exp_ready = 1; exp_under = 0;
      exp_tx = 0; running = 0; widx = 0;
      bitq.delete();
      pending.delete();
    end else begin
      bit            next_tx;
      logic [WB-1:0] w;
      check("nav_bit",        nav_bit,        exp_nav);
      check("subframe_start", subframe_start, exp_sfs);
      check("word_ready",     bus.word_ready, exp_ready);
      check("underrun",       underrun,       exp_under);
      check("tx_chip",        tx_chip,        exp_tx);
      check("bit_strobe",     bit_strobe,     (cyc % CPB) == CPB - 1);
      next_tx   = code_chip ^ exp_nav;
      exp_under = 0;
      if ((cyc % CPB) == CPB - 1) begin
        if (bitq.size() > 0) begin
          exp_nav = bitq.pop_front();
          exp_sfs = 0;
        end else if (pending.size() > 0) begin
          w    = pending.pop_front();
          widx = running ? (widx + 1) % WPS : 0;
          running = 1;
          for (int i = WB - 2; i >= 0; i--) bitq.push_back(w[i]);
          exp_nav = w[WB-1];
          exp_sfs = (widx == 0);
        end else if (running) begin
          running = 0; exp_under = 1; exp_nav = 0; exp_sfs = 0; widx = 0;
        end
      end
      if (bus.word_valid && bus.word_ready) pending.push_back(bus.word_data);
      exp_ready = (pending.size() == 0);
      exp_tx    = next_tx;
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge clk_in);
      #1 code_chip = 1'($urandom);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic offer(input logic [WB-1:0] w);
    bit ok = 1'b0;
    bus.word_data  = w;
    bus.word_valid = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      if (stop_feed) break;
      if (bus.word_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (stop_feed) return;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL offer_timeout @%0t: got word_ready=0, want 1 within 4000 cycles", $time);
    end
    @(posedge clk_in);
    #1 bus.word_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int max_gap);
    for (int k = 0; k < n && !stop_feed; k++) begin
      offer(WB'($urandom));
      if (max_gap > 0 && !stop_feed) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #3 rst = 1'b0;
    bus.word_valid = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk_in);
    #1 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog @%0t: got no finish, want finish", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    #1 rst = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(posedge clk_in);
    #1 rst = 1'b1;

    idle(5 * CPB);                   // idle epochs: no underrun, nav_bit low
    offer(30'h2AAAAAAA);             // alternating pattern word
    idle(34 * CPB);
    feed(11, 0);                     // back-to-back with subframe wrap
    idle(34 * CPB);
    feed(4, 0);                      // stop after word 3, then resume
    idle(3 * CPB);
    offer(WB'($urandom));
    idle(34 * CPB);
    feed(20, 5 * CPB);               // random gaps, some underrun
    idle(34 * CPB);

    // Reset during bit 17 of word 2 with the holding buffer full.
    do_reset();
    stop_feed = 1'b0;
    fork
      feed(10, 0);
      begin
        repeat (627) @(posedge clk_in);
        #3 rst = 1'b0;
        stop_feed      = 1'b1;
        bus.word_valid = 1'b0;
        #1 check_reset_outputs("midword");
      end
    join
    repeat (3) @(posedge clk_in);
    #1 rst = 1'b1;
    idle(6 * CPB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
